// File: rtl/inport_uart_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : inport_uart_source_if
//  Description : Serial line in, packed 32-bit input-port word and status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inport_uart_source_if;
    logic        rx;
    logic [31:0] Inport_In;
    logic        Strobe;
    logic [1:0]  byte_count;
    logic        frame_err;
    logic        parity_err;

    modport master (
        input  rx,
        output Inport_In, Strobe, byte_count, frame_err, parity_err
    );

    modport slave (
        output rx,
        input  Inport_In, Strobe, byte_count, frame_err, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/inport_uart_source.sv
`default_nettype none
// ============================================================================
//  Module      : inport_uart_source
//  Description : UART receiver (8N1, or 8E1 with INPORT_UART_PARITY_EN defined)
//                packing four bytes little-endian into the CPU input-port word.
//  Revision    : 1.0 - initial release
// ============================================================================
module inport_uart_source #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic             clock,
    input  wire logic             clear,
    inport_uart_source_if.master  bus
);
    localparam int              C_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [C_CNT_W-1:0] C_HALF_M1 = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CNT_W-1:0] C_FULL_M1 = C_CNT_W'(CLKS_PER_BIT - 1);

`ifdef INPORT_UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3
    } state_t;
`endif

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [31:0]          buf_q, buf_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [31:0]          inport_q, inport_d;
    logic                 strobe_q, strobe_d;
    logic                 ferr_q, ferr_d;
`ifdef INPORT_UART_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        byte_cnt_d = byte_cnt_q;
        inport_d   = inport_q;
        strobe_d   = 1'b0;
        ferr_d     = 1'b0;
`ifdef INPORT_UART_PARITY_EN
        par_bad_d  = par_bad_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q && rx_prev_q) begin
                    cnt_d   = C_HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    // A line back high at mid-start is a glitch, not a frame.
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = C_FULL_M1;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = C_FULL_M1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef INPORT_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef INPORT_UART_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    par_bad_d = ^{shift_q, rx_s_q};
                    cnt_d     = C_FULL_M1;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
`ifdef INPORT_UART_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        buf_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            inport_d = {shift_q, buf_q[23:0]};
                            strobe_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            buf_q      <= 32'd0;
            byte_cnt_q <= 2'd0;
            inport_q   <= 32'd0;
            strobe_q   <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef INPORT_UART_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= bus.rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            byte_cnt_q <= byte_cnt_d;
            inport_q   <= inport_d;
            strobe_q   <= strobe_d;
            ferr_q     <= ferr_d;
`ifdef INPORT_UART_PARITY_EN
            par_bad_q  <= par_bad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign bus.Inport_In  = inport_q;
    assign bus.Strobe     = strobe_q;
    assign bus.byte_count = byte_cnt_q;
    assign bus.frame_err  = ferr_q;
`ifdef INPORT_UART_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
